// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer
//   Tile-based playfield renderer for a VGA timing front end. A grid of
//   GRID_W x GRID_H cells, each {dirs[3:0], kind[1:0]}, is streamed in one
//   tile row at a time through the write port into a fill bank. The fill bank
//   is promoted to the display bank as the beam leaves each tile row. The
//   playfield is framed by a one-tile border coloured by game status.
//
//   Optional feature: define VGA_COLORBLIND_EN to let the colorblind input
//   remap palette index 1 from 001100 to 001111.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   px, py, visible        current beam position and active-area flag
//   hsync_in, vsync_in     raw syncs, delayed 2 cycles to hsync/vsync
//   line_end, frame_start  timing pulses (bank swap, frame clear)
//   wr_*                   cell write stream (valid/ready)
//   success, failure       border colour select (success wins)
//   colorblind             palette select (see VGA_COLORBLIND_EN)
//   r, g, b                2-bit colour, 2 cycles after px/py
//   drop_count             saturating count of discarded writes
module vga_tile_renderer #(
  parameter int GRID_W    = 18,
  parameter int GRID_H    = 13,
  parameter int TILE_LOG2 = 5,
  parameter int INSET     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                px,
  input  logic [9:0]                py,
  input  logic                      visible,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      line_end,
  input  logic                      frame_start,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [$clog2(GRID_W)-1:0] wr_x,
  input  logic [$clog2(GRID_H)-1:0] wr_y,
  input  logic [3:0]                wr_dirs,
  input  logic [1:0]                wr_kind,
  input  logic                      success,
  input  logic                      failure,
  input  logic                      colorblind,
  output logic [1:0]                r,
  output logic [1:0]                g,
  output logic [1:0]                b,
  output logic                      hsync,
  output logic                      vsync,
  output logic [7:0]                drop_count
);

  localparam int TILE = 1 << TILE_LOG2;
  localparam int RW   = $clog2(GRID_H + 2);
  localparam int TW   = 10 - TILE_LOG2;
  localparam logic [RW-1:0] ROW_SAT = RW'(GRID_H + 1);

  typedef struct packed {
    logic [3:0] dirs;   // bit0 up, bit1 right, bit2 down, bit3 left
    logic [1:0] kind;   // 0 empty, 1 snake, 2 apple
  } cell_t;

  // ---------------------------------------------------------------------------
  // Line banks and write path
  // ---------------------------------------------------------------------------
  cell_t [GRID_W-1:0] r_disp;
  cell_t [GRID_W-1:0] r_fill;
  logic [RW-1:0]      r_disp_row;
  logic               r_rdy_en;     // low only until the first edge out of reset
  logic               r_swap_pend;  // beam just finished the last line of a tile row
  logic [7:0]         r_drop;

  logic w_acc;
  logic w_keep;

  // Ready drops combinationally on frame_start so the clear cycle never
  // accepts a write; the swap cycle is known one cycle ahead.
  assign wr_ready = r_rdy_en & ~frame_start & ~r_swap_pend;
  assign w_acc    = wr_valid & wr_ready;
  assign w_keep   = w_acc && (RW'(wr_y) == r_disp_row) && (32'(wr_x) < GRID_W) &&
                    (r_disp_row != ROW_SAT);
  assign drop_count = r_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp      <= '0;
      r_fill      <= '0;
      r_disp_row  <= '0;
      r_rdy_en    <= 1'b0;
      r_swap_pend <= 1'b0;
      r_drop      <= '0;
    end else begin
      r_rdy_en    <= 1'b1;
      r_swap_pend <= line_end & (&py[TILE_LOG2-1:0]);
      if (w_acc && !w_keep && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;
      if (frame_start) begin
        r_disp_row <= '0;
        r_disp     <= '0;
        r_fill     <= '0;
      end else if (r_swap_pend) begin
        // Promote the filled row; the old display contents are discarded.
        r_disp <= r_fill;
        r_fill <= '0;
        if (r_disp_row != ROW_SAT)
          r_disp_row <= r_disp_row + RW'(1);
      end else begin
        // Writes are never accepted on clear/swap cycles, so merging only
        // happens here. Repeated writes to a cell accumulate.
        for (int i = 0; i < GRID_W; i++) begin
          if (w_keep && (32'(wr_x) == i)) begin
            r_fill[i].dirs <= r_fill[i].dirs | wr_dirs;
            if (wr_kind > r_fill[i].kind)
              r_fill[i].kind <= wr_kind;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: tile coordinates, intra-tile offset, display entry read
  // ---------------------------------------------------------------------------
  logic [TW-1:0] w_tx;
  logic [TW-1:0] w_ty;
  cell_t         w_rd;

  assign w_tx = px[9:TILE_LOG2];
  assign w_ty = py[9:TILE_LOG2];

  // Playfield tile tx maps to entry tx-1; border/outside tiles read empty.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < GRID_W; i++)
      if (32'(w_tx) == i + 1) w_rd = r_disp[i];
  end

  logic                 r_s1_vis;
  logic [TW-1:0]        r_s1_tx;
  logic [TW-1:0]        r_s1_ty;
  logic [TILE_LOG2-1:0] r_s1_ox;
  logic [TILE_LOG2-1:0] r_s1_oy;
  cell_t                r_s1_cell;
  logic                 r_s1_succ;
  logic                 r_s1_fail;
  logic                 r_s1_hs;
  logic                 r_s1_vs;
`ifdef VGA_COLORBLIND_EN
  logic                 r_s1_cb;
`else
  logic                 w_unused_cb;
  assign w_unused_cb = colorblind;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vis  <= 1'b0;
      r_s1_tx   <= '0;
      r_s1_ty   <= '0;
      r_s1_ox   <= '0;
      r_s1_oy   <= '0;
      r_s1_cell <= '0;
      r_s1_succ <= 1'b0;
      r_s1_fail <= 1'b0;
      r_s1_hs   <= 1'b0;
      r_s1_vs   <= 1'b0;
`ifdef VGA_COLORBLIND_EN
      r_s1_cb   <= 1'b0;
`endif
    end else begin
      r_s1_vis  <= visible;
      r_s1_tx   <= w_tx;
      r_s1_ty   <= w_ty;
      r_s1_ox   <= px[TILE_LOG2-1:0];
      r_s1_oy   <= py[TILE_LOG2-1:0];
      r_s1_cell <= w_rd;
      r_s1_succ <= success;
      r_s1_fail <= failure;
      r_s1_hs   <= hsync_in;
      r_s1_vs   <= vsync_in;
`ifdef VGA_COLORBLIND_EN
      r_s1_cb   <= colorblind;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: tile geometry -> palette index -> registered colour
  // ---------------------------------------------------------------------------
  logic       w_border;
  logic       w_outside;
  logic       w_cx, w_cy;       // offset inside the centre band
  logic       w_lo_x, w_hi_x;   // offset in left / right inset band
  logic       w_lo_y, w_hi_y;   // offset in top / bottom inset band
  logic       w_arm;
  logic [1:0] w_idx;
  logic [5:0] w_rgb;

  assign w_border  = (r_s1_tx == '0) || (32'(r_s1_tx) == GRID_W + 1) ||
                     (r_s1_ty == '0) || (32'(r_s1_ty) == GRID_H + 1);
  assign w_outside = (32'(r_s1_tx) > GRID_W + 1) || (32'(r_s1_ty) > GRID_H + 1);
  assign w_lo_x    = 32'(r_s1_ox) < INSET;
  assign w_hi_x    = 32'(r_s1_ox) >= TILE - INSET;
  assign w_lo_y    = 32'(r_s1_oy) < INSET;
  assign w_hi_y    = 32'(r_s1_oy) >= TILE - INSET;
  assign w_cx      = !w_lo_x && !w_hi_x;
  assign w_cy      = !w_lo_y && !w_hi_y;
  // Each arm is a centre-width strip crossing one edge's inset band.
  assign w_arm     = (w_cx && w_lo_y && r_s1_cell.dirs[0]) ||
                     (w_cy && w_hi_x && r_s1_cell.dirs[1]) ||
                     (w_cx && w_hi_y && r_s1_cell.dirs[2]) ||
                     (w_cy && w_lo_x && r_s1_cell.dirs[3]);

  always_comb begin
    w_idx = 2'd0;
    if (!r_s1_vis)
      w_idx = 2'd0;
    else if (w_border)
      w_idx = r_s1_succ ? 2'd1 : (r_s1_fail ? 2'd2 : 2'd3);
    else if (w_outside)
      w_idx = 2'd0;
    else if (w_cx && w_cy)
      w_idx = r_s1_cell.kind;
    else if (w_arm)
      w_idx = 2'd1;
  end

  always_comb begin
    w_rgb = 6'b000000;
    case (w_idx)
      2'd0: w_rgb = 6'b000000;
`ifdef VGA_COLORBLIND_EN
      2'd1: w_rgb = r_s1_cb ? 6'b001111 : 6'b001100;
`else
      2'd1: w_rgb = 6'b001100;
`endif
      2'd2: w_rgb = 6'b110000;
      2'd3: w_rgb = 6'b111111;
      default: w_rgb = 6'b000000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      r     <= w_rgb[5:4];
      g     <= w_rgb[3:2];
      b     <= w_rgb[1:0];
      hsync <= r_s1_hs;
      vsync <= r_s1_vs;
    end
  end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Randomized scoreboard bench for vga_tile_renderer. Expected pixels come from
// a row-level model of the playfield (which grid row is on screen, which cells
// have been written) plus plain tile arithmetic.
module tb_vga_tile_renderer;
  localparam int GW  = 18;
  localparam int GH  = 13;
  localparam int TL  = 5;
  localparam int INS = 4;
  localparam int T   = 1 << TL;
  localparam int XW  = $clog2(GW);
  localparam int YW  = $clog2(GH);
`ifdef VGA_COLORBLIND_EN
  localparam bit CB_EN = 1'b1;
`else
  localparam bit CB_EN = 1'b0;
`endif

  logic          clk, rst;
  logic [9:0]    px, py;
  logic          visible, hsync_in, vsync_in, line_end, frame_start;
  logic          wr_valid, wr_ready;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [3:0]    wr_dirs;
  logic [1:0]    wr_kind;
  logic          success, failure, colorblind;
  logic [1:0]    r, g, b;
  logic          hsync, vsync;
  logic [7:0]    drop_count;

  vga_tile_renderer #(.GRID_W(GW), .GRID_H(GH), .TILE_LOG2(TL), .INSET(INS)) dut (
    .clk(clk), .rst(rst), .px(px), .py(py), .visible(visible),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .line_end(line_end),
    .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_dirs(wr_dirs), .wr_kind(wr_kind),
    .success(success), .failure(failure), .colorblind(colorblind),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x; int y; bit v; bit le; bit fs;
    bit wv; int wx; int wy; int wd; int wk;
    bit s; bit f; bit cb; bit hs; bit vs;
  } stim_t;

  typedef struct { int due; int exp; } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  // ---- reference model (grid rows, not banks) ----
  bit [3:0] c_dirs[16][GW];
  int       c_kind[16][GW];
  int       m_disp_row, m_shown, m_drop;
  bit       m_rdy_en, m_swap_pend;

  function automatic void clear_cells();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < GW; x++) begin
        c_dirs[y][x] = 4'd0;
        c_kind[y][x] = 0;
      end
  endfunction

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int pix_idx(stim_t s);
    int tx = s.x / T, ty = s.y / T, ox = s.x % T, oy = s.y % T;
    bit [3:0] d = 4'd0;
    int k = 0;
    bit cx, cy;
    if (!s.v) return 0;
    if (tx == 0 || tx == GW + 1 || ty == 0 || ty == GH + 1) return s.s ? 1 : (s.f ? 2 : 3);
    if (tx > GW + 1 || ty > GH + 1) return 0;
    if (m_shown >= 0) begin
      d = c_dirs[m_shown][tx-1];
      k = c_kind[m_shown][tx-1];
    end
    cx = (ox >= INS) && (ox < T - INS);
    cy = (oy >= INS) && (oy < T - INS);
    if (cx && cy) return k;
    if ((cx && oy < INS && d[0]) || (cy && ox >= T - INS && d[1]) ||
        (cx && oy >= T - INS && d[2]) || (cy && ox < INS && d[3])) return 1;
    return 0;
  endfunction

  function automatic int pal(int idx, bit cb);
    case (idx)
      1: return (CB_EN && cb) ? 6'b001111 : 6'b001100;
      2: return 6'b110000;
      3: return 6'b111111;
      default: return 6'b000000;
    endcase
  endfunction

  // ---- monitor: pops expectations as their output cycle arrives ----
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.due == cyc) check("pixel", int'({r, g, b, hsync, vsync}), mon_e.exp);
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.x  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 639));
    s.y  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                       : m_disp_row * T + int'($urandom_range(0, T - 1));
    s.v  = $urandom_range(0, 9) != 0;
    s.le = $urandom_range(0, 29) == 0;
    s.fs = 1'b0;
    s.wv = $urandom_range(0, 9) < 6;
    s.wx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(GW, 31)) : int'($urandom_range(0, GW - 1));
    s.wy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : m_disp_row;
    s.wd = int'($urandom_range(0, 15));
    s.wk = int'($urandom_range(0, 3));
    s.s  = $urandom_range(0, 1) == 1;
    s.f  = $urandom_range(0, 1) == 1;
    s.cb = $urandom_range(0, 1) == 1;
    s.hs = $urandom_range(0, 1) == 1;
    s.vs = $urandom_range(0, 1) == 1;
    return s;
  endfunction

  // One clock of stimulus; fexp < 0 means "use the model".
  task automatic step(input stim_t s, input int fexp);
    bit   rdy, keep;
    exp_t e;
    @(negedge clk);
    check("drop_count", int'(drop_count), m_drop);
    px = s.x[9:0]; py = s.y[9:0]; visible = s.v; line_end = s.le; frame_start = s.fs;
    wr_valid = s.wv; wr_x = s.wx[XW-1:0]; wr_y = s.wy[YW-1:0];
    wr_dirs = s.wd[3:0]; wr_kind = s.wk[1:0];
    success = s.s; failure = s.f; colorblind = s.cb; hsync_in = s.hs; vsync_in = s.vs;
    #1;
    rdy = m_rdy_en && !s.fs && !m_swap_pend;
    check("wr_ready", int'(wr_ready), int'(rdy));
    e.due = cyc + 2;
    e.exp = (fexp >= 0) ? fexp : ((pal(pix_idx(s), s.cb) << 2) | (int'(s.hs) << 1) | int'(s.vs));
    q.push_back(e);
    if (s.wv && rdy) begin
      keep = (s.wy == m_disp_row) && (s.wx < GW) && (m_disp_row != GH + 1);
      if (keep) begin
        c_dirs[s.wy][s.wx] |= s.wd[3:0];
        if (s.wk > c_kind[s.wy][s.wx]) c_kind[s.wy][s.wx] = s.wk;
      end else if (m_drop < 255) m_drop++;
    end
    if (s.fs) begin
      clear_cells();
      m_disp_row = 0;
      m_shown = -1;
    end else if (m_swap_pend) begin
      // The row just filled goes on screen; past the last row nothing was filled.
      m_shown = (m_disp_row <= GH) ? m_disp_row : -1;
      if (m_disp_row < GH + 1) m_disp_row++;
    end
    m_swap_pend = s.le && (s.y % T == T - 1);
    m_rdy_en = 1'b1;
  endtask

  task automatic probe(input int x, input int y, input bit sc, input bit fl, input bit cb, input int exp6);
    stim_t s;
    s = idle(); s.v = 1'b1; s.x = x; s.y = y; s.s = sc; s.f = fl; s.cb = cb;
    step(s, exp6 << 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    px = '0; py = '0; visible = 0; line_end = 0; frame_start = 0; wr_valid = 0;
    hsync_in = 0; vsync_in = 0;
    q.delete();
    #1;
    check("rst_out", int'({r, g, b, hsync, vsync}), 0);
    check("rst_drop", int'(drop_count), 0);
    check("rst_ready", int'(wr_ready), 0);
    clear_cells();
    m_disp_row = 0; m_shown = -1; m_drop = 0; m_swap_pend = 1'b0; m_rdy_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hold", int'({r, g, b, hsync, vsync, drop_count}), 0);
    rst = 1'b0;
    #1;
    check("ready_release", int'(wr_ready), 0);
    m_rdy_en = 1'b1;
  endtask

  task automatic rand_frame(input bit writes);
    stim_t s;
    s = rnd(); s.fs = 1'b1; s.wv = 1'b0; step(s, -1);
    for (int row = 0; row < GH + 3; row++) begin
      repeat (40) begin
        s = rnd(); s.wv = s.wv && writes; step(s, -1);
      end
      s = rnd(); s.wv = s.wv && writes; s.le = 1'b1; s.y = m_disp_row * T + T - 1;
      step(s, -1);
    end
  endtask

  initial begin
    stim_t s;
    rst = 1'b1;
    px = '0; py = '0; visible = 0; hsync_in = 0; vsync_in = 0; line_end = 0; frame_start = 0;
    wr_valid = 0; wr_x = '0; wr_y = '0; wr_dirs = '0; wr_kind = '0;
    success = 0; failure = 0; colorblind = 0;
    clear_cells();
    m_disp_row = 0; m_shown = -1; m_drop = 0; m_swap_pend = 1'b0; m_rdy_en = 1'b0;

    do_reset();

    // apple at (3,0), up+down arms and snake centre at (5,0)
    s = idle(); s.fs = 1'b1; step(s, -1);
    s = idle(); s.wv = 1; s.wx = 3; s.wy = 0; s.wk = 2; step(s, -1);
    s = idle(); s.wv = 1; s.wx = 5; s.wy = 0; s.wd = 4'b0001; step(s, -1);
    s = idle(); s.wv = 1; s.wx = 5; s.wy = 0; s.wd = 4'b0100; s.wk = 1; step(s, -1);
    s = idle(); s.le = 1; s.y = T - 1; step(s, -1);
    s = idle(); s.wv = 1; s.wx = 9; s.wy = 1; s.wk = 2; step(s, -1);
    check("ready_swap", int'(wr_ready), 0);
    probe(4*T + 16, T + 16, 0, 0, 0, 6'b110000);
    probe(6*T + 16, T + 1,  0, 0, 0, 6'b001100);
    probe(6*T + 16, T + 30, 0, 0, 0, 6'b001100);
    probe(6*T + 16, T + 16, 0, 0, 0, 6'b001100);
    probe(6*T + 1,  T + 1,  0, 0, 0, 6'b000000);
    probe(6*T + 30, T + 30, 0, 0, 0, 6'b000000);
    probe(6*T + 1,  T + 16, 0, 0, 0, 6'b000000);
    probe(10*T + 16, T + 16, 0, 0, 0, 6'b000000);
    // border colours
    probe(0, T + 16, 1, 1, 0, 6'b001100);
    probe(0, T + 16, 1, 1, 1, CB_EN ? 6'b001111 : 6'b001100);
    probe(0, T + 16, 0, 1, 0, 6'b110000);
    probe((GW+1)*T + 3, T + 16, 0, 0, 0, 6'b111111);
    s = idle(); s.x = 0; s.y = 16; s.s = 1; step(s, 0);

    // write coincident with the swapping line_end lands in the next row
    s = idle(); s.le = 1; s.y = 2*T - 1; s.wv = 1; s.wx = 7; s.wy = 1; s.wk = 2; s.wd = 4'b0010;
    step(s, -1);
    s = idle(); step(s, -1);
    check("ready_swap2", int'(wr_ready), 0);
    s = idle(); step(s, -1);
    check("ready_after_swap", int'(wr_ready), 1);
    probe(8*T + 16, 2*T + 16, 0, 0, 0, 6'b110000);
    probe(8*T + 30, 2*T + 16, 0, 0, 0, 6'b001100);

    // drop counter: wrong row, then saturation
    s = idle(); s.fs = 1'b1; step(s, -1);
    s = idle(); s.wv = 1; s.wx = 1; s.wy = 2; s.wk = 2; step(s, -1);
    @(posedge clk); #1;
    check("drop_one", int'(drop_count), 1);
    repeat (299) step(s, -1);
    @(posedge clk); #1;
    check("drop_sat", int'(drop_count), 255);
    s = idle(); s.le = 1; s.y = T - 1; step(s, -1);
    s = idle(); step(s, -1);
    probe(2*T + 16, T + 16, 0, 0, 0, 6'b000000);

    // randomized frames
    rand_frame(1'b1);
    rand_frame(1'b1);

    // mid-frame reset, then a frame without writes
    s = idle(); s.fs = 1'b1; step(s, -1);
    repeat (100) begin s = rnd(); step(s, -1); end
    do_reset();
    s = idle(); s.fs = 1'b1; step(s, -1);
    s = idle(); s.le = 1; s.y = T - 1; step(s, -1);
    s = idle(); step(s, -1);
    probe(4*T + 16, T + 16, 0, 0, 0, 6'b000000);
    rand_frame(1'b0);
    rand_frame(1'b1);

    repeat (4) begin s = idle(); step(s, -1); end
    repeat (3) @(posedge clk);
    #2;
    check("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
